// File: rtl/dec_sequential.sv
// dec_sequential: sequential BCD-to-binary converter.
// Absorbs DIGITS BCD digits, most significant first, one per dec_valid/dec_ready
// handshake, accumulating acc = acc*10 + digit. Each digit takes two cycles:
// it is accepted in WAIT, then multiply-accumulated in MAC. After the last MAC,
// DONE pulses bin_valid for one cycle and the block returns to IDLE. bin_out
// holds its value until the next dec_start.
//
// Optional build macro: DEC_SEQ_SATURATE_EN
//   undefined : the accumulator wraps modulo 2^BIN_W on overflow
//   defined   : after an overflow the accumulator is pinned to all-ones
// err_ovf behaves the same way in both builds.
module dec_sequential #(
  parameter int unsigned DIGITS = 8,
  parameter int unsigned BIN_W  = 26
) (
  input  logic             SYS_clk,
  input  logic             reset,
  input  logic             dec_start,
  input  logic [3:0]       dec_in,
  input  logic             dec_valid,
  output logic             dec_ready,
  output logic [BIN_W-1:0] bin_out,
  output logic             bin_valid,
  output logic             busy,
  output logic             err_digit,
  output logic             err_ovf
);

  localparam int unsigned CNT_W = $clog2(DIGITS + 1);
  localparam int unsigned SUM_W = BIN_W + 4;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] MAC  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [BIN_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       digit_q, digit_d;
  logic             err_digit_q, err_digit_d;
  logic             err_ovf_q, err_ovf_d;
  logic             dec_ready_q, dec_ready_d;
  logic             bin_valid_q, bin_valid_d;
  logic             busy_q, busy_d;

  logic [SUM_W-1:0] acc_ext;
  logic [SUM_W-1:0] prod_sum;
  logic             mac_ovf;

  // acc*10 + digit, built from shifts; the top 4 bits flag an overflow
  always_comb begin
    acc_ext  = SUM_W'(acc_q);
    prod_sum = (acc_ext << 3) + (acc_ext << 1) + SUM_W'(digit_q);
    mac_ovf  = |prod_sum[SUM_W-1 -: 4];
  end

  // Next-state and next-output logic; dec_start overrides everything else
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    digit_d     = digit_q;
    err_digit_d = err_digit_q;
    err_ovf_d   = err_ovf_q;

    if (dec_start) begin
      state_d     = WAIT;
      acc_d       = '0;
      cnt_d       = CNT_W'(DIGITS);
      digit_d     = 4'd0;
      err_digit_d = 1'b0;
      err_ovf_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = IDLE;
        end
        WAIT: begin
          if (dec_valid) begin
            state_d = MAC;
            if (dec_in > 4'd9) begin
              // An illegal digit is recorded and then treated as zero
              err_digit_d = 1'b1;
              digit_d     = 4'd0;
            end else begin
              digit_d = dec_in;
            end
          end
        end
        MAC: begin
          if (mac_ovf) begin
            err_ovf_d = 1'b1;
          end
`ifdef DEC_SEQ_SATURATE_EN
          if (err_ovf_q || mac_ovf) begin
            acc_d = '1;
          end else begin
            acc_d = prod_sum[BIN_W-1:0];
          end
`else
          acc_d = prod_sum[BIN_W-1:0];
`endif
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = DONE;
          end else begin
            state_d = WAIT;
          end
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    // Status outputs follow the state being entered, so they line up with it
    dec_ready_d = (state_d == WAIT);
    bin_valid_d = (state_d == DONE);
    busy_d      = (state_d == WAIT) || (state_d == MAC);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge SYS_clk) begin
    if (reset) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      digit_q     <= 4'd0;
      err_digit_q <= 1'b0;
      err_ovf_q   <= 1'b0;
      dec_ready_q <= 1'b0;
      bin_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      digit_q     <= digit_d;
      err_digit_q <= err_digit_d;
      err_ovf_q   <= err_ovf_d;
      dec_ready_q <= dec_ready_d;
      bin_valid_q <= bin_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign dec_ready = dec_ready_q;
  assign bin_out   = acc_q;
  assign bin_valid = bin_valid_q;
  assign busy      = busy_q;
  assign err_digit = err_digit_q;
  assign err_ovf   = err_ovf_q;

endmodule

// File: tb/tb_dec_sequential.sv
// Directed testbench for dec_sequential (DIGITS=8, BIN_W=26).
// Inputs change 1ns after each rising edge; outputs are sampled at that same point.
module tb_dec_sequential;

  localparam int unsigned DIGITS = 8;
  localparam int unsigned BIN_W  = 26;

  logic             SYS_clk = 1'b0;
  logic             reset;
  logic             dec_start;
  logic [3:0]       dec_in;
  logic             dec_valid;
  logic             dec_ready;
  logic [BIN_W-1:0] bin_out;
  logic             bin_valid;
  logic             busy;
  logic             err_digit;
  logic             err_ovf;

  int checks = 0;
  int passed = 0;
  int cyc = 0;
  int first_acc = -1;
  int bv_count = 0;

  dec_sequential #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .SYS_clk   (SYS_clk),
    .reset     (reset),
    .dec_start (dec_start),
    .dec_in    (dec_in),
    .dec_valid (dec_valid),
    .dec_ready (dec_ready),
    .bin_out   (bin_out),
    .bin_valid (bin_valid),
    .busy      (busy),
    .err_digit (err_digit),
    .err_ovf   (err_ovf)
  );

  always #5 SYS_clk = ~SYS_clk;

  // Counts bin_valid pulses mid-cycle
  always @(negedge SYS_clk) if (bin_valid === 1'b1) bv_count++;

  task automatic step();
    @(posedge SYS_clk);
    #1;
    cyc++;
  endtask

  task automatic pulse_start();
    dec_start = 1'b1;
    step();
    dec_start = 1'b0;
  endtask

  // Offer one digit after 'gap' idle cycles; returns with the DUT in MAC
  task automatic send_digit(input logic [3:0] d, input int gap);
    int n;
    dec_valid = 1'b0;
    repeat (gap) step();
    dec_in    = d;
    dec_valid = 1'b1;
    n = 0;
    while (dec_ready !== 1'b1 && n < 20) begin step(); n++; end
    checks++;
    if (dec_ready !== 1'b1) $display("FAIL accept_timeout: dec_ready=%b required 1", dec_ready);
    else passed++;
    if (first_acc < 0) first_acc = cyc;
    step();
    dec_valid = 1'b0;
    checks++;
    if (dec_ready !== 1'b0 || busy !== 1'b1)
      $display("FAIL mac_ready: dec_ready=%b busy=%b required 0/1", dec_ready, busy);
    else passed++;
  endtask

  task automatic wait_done(output int at_cyc);
    int n;
    n = 0;
    while (bin_valid !== 1'b1 && n < 40) begin step(); n++; end
    checks++;
    if (bin_valid !== 1'b1) $display("FAIL done_timeout: bin_valid=%b required 1", bin_valid);
    else passed++;
    at_cyc = cyc;
  endtask

  task automatic test_reset();
    reset = 1'b1; dec_start = 1'b0; dec_in = 4'd0; dec_valid = 1'b0;
    step(); step();
    reset = 1'b0;
    checks++;
    if ({dec_ready, bin_valid, busy, err_digit, err_ovf} !== 5'b0 || bin_out !== '0)
      $display("FAIL reset_state: rdy=%b bv=%b busy=%b ed=%b eo=%b out=%h required all 0",
               dec_ready, bin_valid, busy, err_digit, err_ovf, bin_out);
    else passed++;
    dec_valid = 1'b1; dec_in = 4'd7;
    repeat (3) step();
    dec_valid = 1'b0;
    checks++;
    if (dec_ready !== 1'b0 || busy !== 1'b0 || bin_out !== '0)
      $display("FAIL idle_ignores_valid: rdy=%b busy=%b out=%h required 0/0/0", dec_ready, busy, bin_out);
    else passed++;
  endtask

  task automatic test_back_to_back();
    logic [3:0] d [8] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8};
    int done_cyc;
    first_acc = -1;
    pulse_start();
    checks++;
    if (dec_ready !== 1'b1 || busy !== 1'b1 || bin_out !== '0)
      $display("FAIL start_wait: rdy=%b busy=%b out=%h required 1/1/0", dec_ready, busy, bin_out);
    else passed++;
    for (int i = 0; i < 8; i++) send_digit(d[i], 0);
    step();
    wait_done(done_cyc);
    checks++;
    if (done_cyc - first_acc + 1 !== 2 * DIGITS + 1)
      $display("FAIL latency: got %0d cycles required %0d", done_cyc - first_acc + 1, 2 * DIGITS + 1);
    else passed++;
    checks++;
    if (bin_out !== 26'hBC614E || err_digit !== 1'b0 || err_ovf !== 1'b0 || busy !== 1'b0)
      $display("FAIL b2b_result: out=%h ed=%b eo=%b busy=%b required bc614e/0/0/0",
               bin_out, err_digit, err_ovf, busy);
    else passed++;
    step();
    checks++;
    if (bin_valid !== 1'b0 || dec_ready !== 1'b0 || bin_out !== 26'hBC614E)
      $display("FAIL b2b_after: bv=%b rdy=%b out=%h required 0/0/bc614e", bin_valid, dec_ready, bin_out);
    else passed++;
  endtask

  task automatic test_max_value();
    logic [3:0] d [8] = '{4'd6, 4'd7, 4'd1, 4'd0, 4'd8, 4'd8, 4'd6, 4'd3};
    int done_cyc;
    pulse_start();
    for (int i = 0; i < 8; i++) send_digit(d[i], i % 2);
    wait_done(done_cyc);
    checks++;
    if (bin_out !== 26'h3FFFFFF || err_ovf !== 1'b0)
      $display("FAIL max_value: out=%h eo=%b required 3ffffff/0", bin_out, err_ovf);
    else passed++;
  endtask

  task automatic test_overflow();
    int done_cyc;
    logic [BIN_W-1:0] exp_out;
`ifdef DEC_SEQ_SATURATE_EN
    exp_out = 26'h3FFFFFF;
`else
    exp_out = 26'h1F5E0FF;
`endif
    pulse_start();
    for (int i = 0; i < 8; i++) send_digit(4'd9, 0);
    wait_done(done_cyc);
    checks++;
    if (bin_out !== exp_out || err_ovf !== 1'b1 || err_digit !== 1'b0)
      $display("FAIL overflow: out=%h eo=%b ed=%b required %h/1/0", bin_out, err_ovf, err_digit, exp_out);
    else passed++;
  endtask

  task automatic test_bad_digit();
    int done_cyc;
    pulse_start();
    for (int i = 0; i < 7; i++) send_digit(4'd0, 0);
    send_digit(4'hA, 1);
    checks++;
    if (err_digit !== 1'b1)
      $display("FAIL bad_digit_flag: ed=%b required 1", err_digit);
    else passed++;
    wait_done(done_cyc);
    checks++;
    if (bin_out !== '0 || err_digit !== 1'b1 || err_ovf !== 1'b0)
      $display("FAIL bad_digit_result: out=%h ed=%b eo=%b required 0/1/0", bin_out, err_digit, err_ovf);
    else passed++;
    step();
    pulse_start();
    checks++;
    if (err_digit !== 1'b0 || dec_ready !== 1'b1)
      $display("FAIL start_clears_err: ed=%b rdy=%b required 0/1", err_digit, dec_ready);
    else passed++;
  endtask

  task automatic test_restart_gaps();
    int gaps [8] = '{1, 0, 3, 0, 2, 0, 1, 2};
    int done_cyc;
    int base;
    pulse_start();
    base = bv_count;
    send_digit(4'd1, 2);
    send_digit(4'd2, 0);
    send_digit(4'd3, 1);
    step();
    checks++;
    if (bin_out !== 26'd123)
      $display("FAIL partial_acc: out=%0d required 123", bin_out);
    else passed++;
    pulse_start();
    checks++;
    if (bin_out !== '0 || dec_ready !== 1'b1)
      $display("FAIL restart_clear: out=%0d rdy=%b required 0/1", bin_out, dec_ready);
    else passed++;
    for (int i = 0; i < 7; i++) send_digit(4'd0, gaps[i]);
    send_digit(4'd5, gaps[7]);
    wait_done(done_cyc);
    checks++;
    if (bin_out !== 26'd5)
      $display("FAIL restart_result: out=%0d required 5", bin_out);
    else passed++;
    repeat (3) step();
    checks++;
    if (bv_count - base !== 1)
      $display("FAIL restart_pulses: got %0d bin_valid pulses required 1", bv_count - base);
    else passed++;
  endtask

  task automatic test_reset_mid();
    int base;
    int done_cyc;
    pulse_start();
    base = bv_count;
    send_digit(4'd4, 0);
    send_digit(4'd3, 0);
    step();
    send_digit(4'd2, 0);
    step();
    send_digit(4'd1, 0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if ({dec_ready, bin_valid, busy, err_digit, err_ovf} !== 5'b0 || bin_out !== '0)
      $display("FAIL mid_reset: rdy=%b bv=%b busy=%b ed=%b eo=%b out=%h required all 0",
               dec_ready, bin_valid, busy, err_digit, err_ovf, bin_out);
    else passed++;
    dec_valid = 1'b1; dec_in = 4'd9;
    repeat (20) step();
    dec_valid = 1'b0;
    checks++;
    if (dec_ready !== 1'b0 || busy !== 1'b0 || bin_out !== '0 || bv_count - base !== 0)
      $display("FAIL mid_reset_idle: rdy=%b busy=%b out=%h pulses=%0d required 0/0/0/0",
               dec_ready, busy, bin_out, bv_count - base);
    else passed++;
    pulse_start();
    for (int i = 0; i < 8; i++) send_digit(4'(i), 0);
    wait_done(done_cyc);
    checks++;
    if (bin_out !== 26'd1234567)
      $display("FAIL post_reset_conv: out=%0d required 1234567", bin_out);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_max_value();
    test_overflow();
    test_bad_digit();
    test_restart_gaps();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/dec_sequential.md
Name: dec_sequential

Overview:
Sequential decimal-to-binary converter. It is the inverse of the team's sequential binary-to-decimal converter. It accepts up to DIGITS BCD digits, most significant first, one per handshake, and accumulates acc = acc*10 + digit. When the last digit is absorbed it presents a BIN_W-bit binary result. It sits between a digit source (keypad or serial decimal field parser) and binary consumers.

Parameters:
DIGITS, 8, number of decimal digits per conversion (1..15)
BIN_W, 26, width of the binary result

Ports:
SYS_clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous reset, active-high
dec_start  input  1  begin new conversion; clears accumulator and flags
dec_in  input  4  BCD digit, MSB digit first
dec_valid  input  1  dec_in valid this cycle
dec_ready  output  1  block can accept a digit this cycle
bin_out  output  BIN_W  accumulated binary value
bin_valid  output  1  one-cycle pulse: conversion complete, bin_out final
busy  output  1  conversion in progress (state WAIT or MAC)
err_digit  output  1  sticky: a digit > 9 was received
err_ovf  output  1  sticky: result exceeded 2^BIN_W - 1

Behaviour:
- Reset: the state is IDLE. bin_out=0, bin_valid=0, dec_ready=0, busy=0, err_digit=0, err_ovf=0, digit counter=0.
- Reset has priority over dec_start. dec_start has priority over all other activity.
- Reset asserted mid-conversion aborts it with no bin_valid pulse.
- The state machine has four states: IDLE, WAIT, MAC, DONE.
- dec_start (any state): acc/bin_out<=0, cnt<=DIGITS, err_digit<=0, err_ovf<=0, bin_valid<=0, next state WAIT.
  - A dec_valid in the same cycle as dec_start is ignored.
  - dec_start mid-conversion discards the partial result.
- IDLE: dec_ready=0. dec_valid is ignored. Remain until dec_start.
- WAIT: dec_ready=1.
  - If dec_valid=1: latch dec_in into the digit register and go to MAC.
  - If dec_in > 9: set err_digit, latch digit as 0.
- MAC: dec_ready=0. Compute the (BIN_W+4)-bit product-sum acc*10 + digit, using (acc<<3)+(acc<<1)+digit.
  - If the upper 4 bits are nonzero, set err_ovf.
  - acc <= low BIN_W bits. Wrap is modulo 2^BIN_W, so the final value equals the true value mod 2^BIN_W.
  - cnt <= cnt-1.
  - If cnt was 1, go to DONE; else go to WAIT.
- DONE: bin_valid=1 for exactly one cycle, then go to IDLE.
- bin_out equals acc at all times and holds after DONE until the next dec_start.
- Latency:
  - Each digit takes 2 cycles (accept in WAIT, MAC).
  - With back-to-back dec_valid, bin_valid rises 2*DIGITS+1 cycles after the first digit-accept cycle.
- The source may stall arbitrarily in WAIT. There is no timeout.
- busy=1 in WAIT and MAC; busy=0 in IDLE and DONE.

Optional Feature:
Macro DEC_SEQ_SATURATE_EN.
- Defined: once err_ovf is set, acc is forced to all-ones (2^BIN_W-1) and held there for the remaining digits.
- Not defined: wrap modulo 2^BIN_W as above.
- err_ovf behaviour is identical in both builds.

Test Plan:
- dec_start, digits 1,2,3,4,5,6,7,8 back-to-back -> bin_valid pulse 17 cycles after the first accept, bin_out=0xBC614E, no errors, dec_ready low in every MAC cycle.
- dec_start, digits 6,7,1,0,8,8,6,3 -> bin_out=0x3FFFFFF, err_ovf=0.
- Digits 9 x8 -> err_ovf=1; bin_out=0x1F5E0FF without DEC_SEQ_SATURATE_EN, 0x3FFFFFF with it.
- Digits 0,0,0,0,0,0,0,0xA -> err_digit=1, bin_out=0. A following dec_start clears err_digit.
- Digits 1,2,3, then dec_start, then 0 x7 followed by 5, with random dec_valid gaps -> bin_out=5, exactly one bin_valid pulse.
- reset during the 4th digit's MAC -> all outputs 0 the next cycle, state IDLE, no bin_valid; dec_valid ignored until dec_start.
